// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
//   op_e    : instruction operation (bit 1 = divide, bit 0 = signed)
//   state_e : sequencer FSM states
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   function automatic logic op_is_div(input op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath shared by multiply and divide.
//   Multiply (mode_div=0): radix-2 shift-add. opnd = multiplicand, lo starts as
//     the multiplier; after WIDTH steps {hi,lo} is the 2*WIDTH product.
//   Divide (mode_div=1): restoring shift-subtract. opnd = divisor, lo starts as
//     the dividend; after WIDTH steps lo = quotient, hi = remainder.
// Ports
//   Clk, Rst   clock, synchronous active-high reset
//   load       capture load_opnd/load_lo, clear hi
//   en         perform one iteration
//   mode_div   0 multiply, 1 divide
//   load_opnd  multiplicand or divisor magnitude
//   load_lo    multiplier or dividend magnitude
//   hi, lo     accumulator halves
module muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             load,
   input  logic             en,
   input  logic             mode_div,
   input  logic [WIDTH-1:0] load_opnd,
   input  logic [WIDTH-1:0] load_lo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      // Multiply: add the multiplicand when the current multiplier bit is set,
      // keep the carry and shift the whole {carry,hi,lo} right by one.
      sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
      // Divide: partial remainder is WIDTH+1 bits wide; a set MSB of the
      // difference means the trial subtract went negative and is discarded.
      shifted = {hi_q, lo_q[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_q};
      if (load) begin
         opnd_d = load_opnd;
         hi_d   = '0;
         lo_d   = load_lo;
      end else if (en) begin
         if (mode_div) begin
            if (!diff[WIDTH]) begin
               hi_d = diff[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = shifted[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         opnd_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         opnd_q <= opnd_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding the HiLo register.
// Captures operands on Start, runs WIDTH iterations in muldiv_core, applies
// sign correction, then issues a single HiLoEn strobe.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for Start; operands captured on Start
//   S_RUN  | one core iteration per cycle, count runs WIDTH-1 down to 0
//   S_FIX  | sign correction / divide-by-zero override into HiLoWrite
//   S_DONE | HiLoEn strobe (Stall released); Start ignored
//
// Ports
//   Clk        datapath clock
//   Rst        synchronous active-high reset (aborts any operation)
//   Start      mul/div instruction present this cycle
//   Op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B       multiplicand/dividend, multiplier/divisor
//   Stall      hold PC and suppress RegWrite (combinational)
//   Busy       registered, state != IDLE
//   HiLoEn     one-cycle HiLo write strobe
//   HiLoWrite  {Hi,Lo} result, valid with HiLoEn
//   DivByZero  pulses with HiLoEn for a divide with B == 0
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic [1:0]         Op,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               Stall,
   output logic               Busy,
   output logic               HiLoEn,
   output logic [2*WIDTH-1:0] HiLoWrite,
   output logic               DivByZero
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   op_e                op_q, op_d;
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic               busy_q, busy_d;
   logic               hilo_en_q, hilo_en_d;
   logic               div_by_zero_q, div_by_zero_d;
   logic [2*WIDTH-1:0] hilo_write_q, hilo_write_d;

   op_e                op_in;
   logic               a_sgn, b_sgn;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               core_load, core_en;
   logic [WIDTH-1:0]   core_hi, core_lo;
   logic [2*WIDTH-1:0] product;

   assign op_in   = op_e'(Op);
   assign a_sgn   = op_is_signed(op_in) & A[WIDTH-1];
   assign b_sgn   = op_is_signed(op_in) & B[WIDTH-1];
   assign a_mag   = a_sgn ? -A : A;
   assign b_mag   = b_sgn ? -B : B;
   assign product = {core_hi, core_lo};

   assign core_load = (state_q == S_IDLE) & Start;
   assign core_en   = (state_q == S_RUN);

   muldiv_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .Clk       (Clk),
      .Rst       (Rst),
      .load      (core_load),
      .en        (core_en),
      .mode_div  (op_is_div(op_q)),
      .load_opnd (op_is_div(op_in) ? b_mag : a_mag),
      .load_lo   (op_is_div(op_in) ? a_mag : b_mag),
      .hi        (core_hi),
      .lo        (core_lo)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      op_d          = op_q;
      neg_d         = neg_q;
      rem_neg_d     = rem_neg_q;
      dbz_d         = dbz_q;
      a_raw_d       = a_raw_q;
      hilo_en_d     = 1'b0;
      div_by_zero_d = 1'b0;
      hilo_write_d  = hilo_write_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d   = S_RUN;
               count_d   = CW'(WIDTH - 1);
               op_d      = op_in;
               neg_d     = a_sgn ^ b_sgn;
               rem_neg_d = a_sgn;
               dbz_d     = op_is_div(op_in) & (B == '0);
               a_raw_d   = A;
            end
         end
         S_RUN: begin
            if (count_q == '0) begin
               state_d = S_FIX;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         S_FIX: begin
            state_d       = S_DONE;
            hilo_en_d     = 1'b1;
            div_by_zero_d = dbz_q;
            if (!op_is_div(op_q)) begin
               hilo_write_d = neg_q ? -product : product;
            end else if (dbz_q) begin
               // Divide by zero: Hi echoes the dividend as supplied, Lo saturates.
               hilo_write_d = {a_raw_q, {WIDTH{1'b1}}};
            end else begin
               hilo_write_d = {(rem_neg_q ? -core_hi : core_hi),
                               (neg_q     ? -core_lo : core_lo)};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q       <= S_IDLE;
         count_q       <= '0;
         op_q          <= OP_MULTU;
         neg_q         <= 1'b0;
         rem_neg_q     <= 1'b0;
         dbz_q         <= 1'b0;
         a_raw_q       <= '0;
         busy_q        <= 1'b0;
         hilo_en_q     <= 1'b0;
         div_by_zero_q <= 1'b0;
         hilo_write_q  <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         op_q          <= op_d;
         neg_q         <= neg_d;
         rem_neg_q     <= rem_neg_d;
         dbz_q         <= dbz_d;
         a_raw_q       <= a_raw_d;
         busy_q        <= busy_d;
         hilo_en_q     <= hilo_en_d;
         div_by_zero_q <= div_by_zero_d;
         hilo_write_q  <= hilo_write_d;
      end
   end

   // Released in DONE so the PC advances on the same edge that writes HiLo.
   assign Stall = ((state_q == S_IDLE) & Start & ~Rst) |
                  (state_q == S_RUN) | (state_q == S_FIX);

   assign Busy      = busy_q;
   assign HiLoEn    = hilo_en_q;
   assign HiLoWrite = hilo_write_q;
   assign DivByZero = div_by_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latency,
// strobe count, reset abort and Start-held behaviour.
module tb_muldiv_sequencer;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Stall;
   logic        Busy;
   logic        HiLoEn;
   logic [63:0] HiLoWrite;
   logic        DivByZero;

   int n_cmp;
   int n_err;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .Op        (Op),
      .A         (A),
      .B         (B),
      .Stall     (Stall),
      .Busy      (Busy),
      .HiLoEn    (HiLoEn),
      .HiLoWrite (HiLoWrite),
      .DivByZero (DivByZero)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start an op, watch 40 cycles. Cycle 0 is the cycle Start is sampled.
   task automatic do_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input logic exp_dbz,
                        input bit hold, input bit scramble);
      int          en_cyc;
      int          stall_end;
      int          pulses;
      logic [63:0] res;
      logic        dbz;
      en_cyc    = -1;
      stall_end = -1;
      pulses    = 0;
      res       = '0;
      dbz       = 1'b0;
      @(posedge Clk); #1;
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         if (!Stall && stall_end < 0) stall_end = c;
         if (HiLoEn) begin
            pulses++;
            if (en_cyc < 0) begin
               en_cyc = c;
               res    = HiLoWrite;
               dbz    = DivByZero;
            end
         end
         @(posedge Clk); #1;
         if (!hold || c >= 34) Start = 1'b0;
         if (scramble) begin
            A  = $urandom;
            B  = $urandom;
            Op = 2'($urandom_range(0, 3));
         end
      end
      Start = 1'b0;
      chk_eq({tag, " stall_end"}, 64'(stall_end), 64'd34);
      chk_eq({tag, " en_cycle"}, 64'(en_cyc), 64'd34);
      chk_eq({tag, " pulses"}, 64'(pulses), 64'd1);
      chk_eq({tag, " result"}, res, exp_res);
      chk_eq({tag, " dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
      chk_eq({tag, " busy_after"}, {63'd0, Busy}, 64'd0);
   endtask

   initial begin
      int pulses;
      n_cmp = 0;
      n_err = 0;
      Rst   = 1'b1;
      Start = 1'b0;
      Op    = 2'b00;
      A     = '0;
      B     = '0;
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b0;
      @(negedge Clk);
      chk_eq("rst busy", {63'd0, Busy}, 64'd0);
      chk_eq("rst hiloen", {63'd0, HiLoEn}, 64'd0);
      chk_eq("rst hilowrite", HiLoWrite, 64'd0);
      chk_eq("rst dbz", {63'd0, DivByZero}, 64'd0);
      chk_eq("rst stall", {63'd0, Stall}, 64'd0);

      do_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 1'b0);
      do_op("mult_neg",   2'b01, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, 1'b0);
      do_op("div_neg",    2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
      do_op("divu_zero",  2'b10, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
      do_op("div_wrap",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0);
      do_op("div_wrap_scr", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b1);
      do_op("divu_100_7", 2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 1'b0, 1'b0, 1'b0);
      do_op("multu_sh",   2'b00, 32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780, 1'b0, 1'b0, 1'b0);
      do_op("mult_m1m1",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0);
      do_op("div_7_m2",   2'b11, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
      do_op("div_zero_s", 2'b11, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
      do_op("hold_start", 2'b00, 32'd6,         32'd7,         64'h0000_0000_0000_002A, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of RUN aborts with no strobe.
      @(posedge Clk); #1;
      Start = 1'b1;
      Op    = 2'b10;
      A     = 32'd1000;
      B     = 32'd3;
      for (int c = 0; c < 11; c++) begin
         @(posedge Clk); #1;
         Start = 1'b0;
      end
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      chk_eq("abort stall", {63'd0, Stall}, 64'd0);
      chk_eq("abort busy", {63'd0, Busy}, 64'd0);
      chk_eq("abort hilowrite", HiLoWrite, 64'd0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         if (HiLoEn) pulses++;
      end
      chk_eq("abort pulses", 64'(pulses), 64'd0);

      do_op("after_abort", 2'b10, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
